// File: rtl/mem_defs_pkg.sv
// Shared encodings for the memory-access stage: access sizes and FSM states.
package mem_defs_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

  // A halfword needs an even address; a word (or the unused size 11) needs a
  // 4-byte aligned address. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = off[0];
      default:    mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane steering for the data bus: store byte-enables and replicated write
// data, and load byte/half/word extraction with sign or zero extension.
module mem_lsu_align
  import mem_defs_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enable the addressed lanes and replicate data into every lane.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      MEM_SIZE_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_SIZE_H: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    ld_byte   = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half   = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      MEM_SIZE_B: ld_data_o = ld_unsigned_i ? {24'b0, ld_byte}
                                            : {{24{ld_byte[7]}}, ld_byte};
      MEM_SIZE_H: ld_data_o = ld_unsigned_i ? {16'b0, ld_half}
                                            : {{16{ld_half[15]}}, ld_half};
      default:    ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/gnt/rvalid data bus for loads and
// stores, stalls upstream while an access is outstanding, and passes
// non-memory instructions straight through in the same cycle.
module mem_stage
  import mem_defs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_reg_valid_i,
  input  logic [31:0] ex_mem_reg_op_c_i,
  input  logic [31:0] ex_mem_reg_op_b_i,
  input  logic [4:0]  ex_mem_reg_reg_waddr_i,
  input  logic        ex_mem_reg_reg_we_i,
  input  logic        ex_mem_reg_mem_re_i,
  input  logic        ex_mem_reg_mem_we_i,
  input  logic [1:0]  ex_mem_reg_mem_size_i,
  input  logic        ex_mem_reg_mem_unsigned_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_op_c_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic        mem_stall_o,
  output logic        mem_misalign_o,
  output logic        mem_bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       off_q;

  logic        is_mem, misal, mem_go, passthru, timeout, complete;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign is_mem   = ex_mem_reg_valid_i & (ex_mem_reg_mem_re_i | ex_mem_reg_mem_we_i);
  assign misal    = is_mem & is_misaligned(ex_mem_reg_mem_size_i, ex_mem_reg_op_c_i[1:0]);
  assign mem_go   = is_mem & ~misal;
  assign passthru = ex_mem_reg_valid_i & ~(ex_mem_reg_mem_re_i | ex_mem_reg_mem_we_i);
  assign timeout  = (state_q == WAIT_RVALID) & ~dmem_rvalid_i & (cnt_q == CNT_LAST);
  assign complete = (state_q == WAIT_RVALID) & (dmem_rvalid_i | timeout);

  mem_lsu_align u_align (
    .st_size_i     (ex_mem_reg_mem_size_i),
    .st_off_i      (ex_mem_reg_op_c_i[1:0]),
    .st_data_i     (ex_mem_reg_op_b_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (dmem_rdata_i),
    .ld_data_o     (ld_data)
  );

  // Access FSM, response timeout counter and the load-format latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_go) begin
            size_q  <= ex_mem_reg_mem_size_i;
            uns_q   <= ex_mem_reg_mem_unsigned_i;
            off_q   <= ex_mem_reg_op_c_i[1:0];
            cnt_q   <= '0;
            state_q <= dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (dmem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (complete) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus and writeback outputs; everything is forced low while in reset.
  always_comb begin
    dmem_req_o      = 1'b0;
    dmem_we_o       = 1'b0;
    dmem_addr_o     = '0;
    dmem_be_o       = '0;
    dmem_wdata_o    = '0;
    mem_valid_o     = 1'b0;
    mem_op_c_o      = '0;
    mem_reg_waddr_o = '0;
    mem_reg_we_o    = 1'b0;
    mem_stall_o     = 1'b0;
    mem_misalign_o  = 1'b0;
    mem_bus_err_o   = 1'b0;
    if (!rst) begin
      dmem_req_o = ((state_q == IDLE) & mem_go) | (state_q == WAIT_GNT);
      if (dmem_req_o) begin
        dmem_we_o    = ex_mem_reg_mem_we_i;
        dmem_addr_o  = {ex_mem_reg_op_c_i[31:2], 2'b00};
        dmem_be_o    = st_be;
        dmem_wdata_o = ex_mem_reg_mem_we_i ? st_wdata : 32'h0;
      end
      mem_stall_o    = mem_go & ~complete;
      mem_misalign_o = misal;
      mem_bus_err_o  = timeout;
      mem_valid_o    = passthru | misal | complete;
      if (mem_valid_o) begin
        mem_reg_waddr_o = ex_mem_reg_reg_waddr_i;
        mem_op_c_o      = ex_mem_reg_op_c_i;
      end
      if (complete & dmem_rvalid_i & ex_mem_reg_mem_re_i)
        mem_op_c_o = ld_data;
      if (passthru | (complete & dmem_rvalid_i))
        mem_reg_we_o = ex_mem_reg_reg_we_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked against a
// byte-arithmetic reference of the load/store lane rules.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, reg_we, mem_re, mem_we, mem_uns;
  logic [31:0] op_c, op_b;
  logic [4:0]  waddr;
  logic [1:0]  msize;
  logic        req, dwe, gnt, rvalid;
  logic [31:0] daddr, wdata, rdata;
  logic [3:0]  be;
  logic        o_valid, o_we, o_stall, o_mis, o_err;
  logic [31:0] o_op_c;
  logic [4:0]  o_waddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .ex_mem_reg_valid_i        (valid),
    .ex_mem_reg_op_c_i         (op_c),
    .ex_mem_reg_op_b_i         (op_b),
    .ex_mem_reg_reg_waddr_i    (waddr),
    .ex_mem_reg_reg_we_i       (reg_we),
    .ex_mem_reg_mem_re_i       (mem_re),
    .ex_mem_reg_mem_we_i       (mem_we),
    .ex_mem_reg_mem_size_i     (msize),
    .ex_mem_reg_mem_unsigned_i (mem_uns),
    .dmem_req_o                (req),
    .dmem_we_o                 (dwe),
    .dmem_addr_o               (daddr),
    .dmem_be_o                 (be),
    .dmem_wdata_o              (wdata),
    .dmem_gnt_i                (gnt),
    .dmem_rvalid_i             (rvalid),
    .dmem_rdata_i              (rdata),
    .mem_valid_o               (o_valid),
    .mem_op_c_o                (o_op_c),
    .mem_reg_waddr_o           (o_waddr),
    .mem_reg_we_o              (o_we),
    .mem_stall_o               (o_stall),
    .mem_misalign_o            (o_mis),
    .mem_bus_err_o             (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: number of bytes touched by an access size (11 behaves as word).
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] s, input logic [1:0] off);
    int n = nbytes(s);
    int v = ((1 << n) - 1) << ((n == 4) ? 0 : int'(off));
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] b);
    case (nbytes(s))
      1:       return (b & 32'hFF) * 32'h0101_0101;
      2:       return (b & 32'hFFFF) * 32'h0001_0001;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic u,
                                           input logic [1:0] off, input logic [31:0] rd);
    int n = nbytes(s);
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    longint unsigned v = (longint'(rd) >> (8 * ((n == 4) ? 0 : int'(off)))) & mask;
    if (!u && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; mem_re = 0; mem_we = 0; reg_we = 0; mem_uns = 0;
    op_c = 0; op_b = 0; waddr = 0; msize = 0; gnt = 0; rvalid = 0; rdata = 0;
  endtask

  task automatic alu_op(input logic [31:0] c, input logic [4:0] wa, input logic w);
    valid = 1; mem_re = 0; mem_we = 0; op_c = c; waddr = wa; reg_we = w;
    @(negedge clk);
    chk("alu_valid", o_valid, 1);
    chk("alu_op_c", o_op_c, c);
    chk("alu_waddr", o_waddr, wa);
    chk("alu_we", o_we, w);
    chk("alu_stall", o_stall, 0);
    chk("alu_req", req, 0);
    next_cycle();
    valid = 0;
  endtask

  // Runs one load/store; gnt comes gd cycles after the request, rvalid rd
  // cycles into the response wait (rd >= TO means it never comes).
  task automatic mem_op(input logic ld, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                        input logic w, input int gd, input int rd, input logic [31:0] rdat);
    logic mis = (nbytes(s) == 2 && a[0]) || (nbytes(s) == 4 && a[1:0] != 0);
    valid = 1; mem_re = ld; mem_we = !ld; msize = s; mem_uns = u;
    op_c = a; op_b = b; waddr = wa; reg_we = w;
    if (mis) begin
      @(negedge clk);
      chk("mis_pulse", o_mis, 1);
      chk("mis_req", req, 0);
      chk("mis_valid", o_valid, 1);
      chk("mis_we", o_we, 0);
      chk("mis_stall", o_stall, 0);
      next_cycle();
      valid = 0; mem_re = 0; mem_we = 0;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      gnt = (i == gd);
      @(negedge clk);
      chk("req", req, 1);
      chk("req_we", dwe, !ld);
      chk("req_addr", daddr, a & 32'hFFFF_FFFC);
      chk("req_stall", o_stall, 1);
      chk("req_valid", o_valid, 0);
      if (!ld) begin
        chk("st_be", be, ref_be(s, a[1:0]));
        chk("st_wdata", wdata, ref_wdata(s, b));
      end
      next_cycle();
    end
    gnt = 0;
    for (int k = 0; k < TO; k++) begin
      rvalid = (k == rd);
      rdata = rdat;
      @(negedge clk);
      chk("rsp_req", req, 0);
      if (k == rd) begin
        chk("done_valid", o_valid, 1);
        chk("done_stall", o_stall, 0);
        chk("done_err", o_err, 0);
        chk("done_we", o_we, w);
        chk("done_waddr", o_waddr, wa);
        if (ld) chk("ld_data", o_op_c, ref_load(s, u, a[1:0], rdat));
        break;
      end else if (k == TO - 1) begin
        chk("to_err", o_err, 1);
        chk("to_valid", o_valid, 1);
        chk("to_we", o_we, 0);
        chk("to_stall", o_stall, 0);
      end else begin
        chk("wait_stall", o_stall, 1);
        chk("wait_valid", o_valid, 0);
        chk("wait_err", o_err, 0);
      end
      next_cycle();
    end
    if (rd < TO) next_cycle();
    valid = 0; mem_re = 0; mem_we = 0; rvalid = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    valid = 1; op_c = 32'h55; waddr = 5'd3; reg_we = 1;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_op_c", o_op_c, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_req", req, 0);
    next_cycle();
    rst = 0;
    idle_inputs();
    next_cycle();

    alu_op(32'h1234, 5'd5, 1'b1);
    mem_op(1, 2'd0, 0, 32'h103, 0, 5'd7, 1, 0, 2, 32'h80FF_FF00);
    chk("lb_value", ref_load(2'd0, 0, 2'd3, 32'h80FF_FF00), 32'hFFFF_FF80);
    mem_op(1, 2'd0, 1, 32'h103, 0, 5'd7, 1, 0, 2, 32'h80FF_FF00);
    mem_op(0, 2'd1, 0, 32'h202, 32'hABCD, 5'd0, 0, 3, 1, 32'hDEAD_BEEF);
    mem_op(1, 2'd2, 0, 32'h301, 0, 5'd9, 1, 0, 0, 0);
    mem_op(1, 2'd2, 0, 32'h400, 0, 5'd9, 1, 0, 100, 0);
    alu_op(32'hCAFE_0001, 5'd1, 1'b1);

    // Reset in the middle of a response wait; the late rvalid must be dropped.
    valid = 1; mem_re = 1; msize = 2'd2; op_c = 32'h500; waddr = 5'd4; reg_we = 1; gnt = 1;
    next_cycle();
    gnt = 0;
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("midrst_stall", o_stall, 0);
    chk("midrst_valid", o_valid, 0);
    next_cycle();
    rst = 0;
    idle_inputs();
    rvalid = 1; rdata = 32'h1111_2222;
    @(negedge clk);
    chk("stale_valid", o_valid, 0);
    chk("stale_err", o_err, 0);
    next_cycle();
    rvalid = 0;
    mem_op(1, 2'd1, 0, 32'h602, 0, 5'd6, 1, 0, 0, 32'h8001_7FFF);

    for (int t = 0; t < 150; t++) begin
      int kind = $urandom_range(0, 2);
      int rdly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      if (kind == 0)
        alu_op($urandom, 5'($urandom), 1'($urandom));
      else
        mem_op(kind == 1, 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
               1'($urandom), $urandom_range(0, 3), rdly, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
